// File: rtl/text_line_fetcher.sv
// Text line fetcher: holds a ROWS x COLS character window, prefetches the glyph
// rows needed for the next scanline during horizontal blank through a shared
// registered font ROM, then serializes them into a per-pixel is_text flag.
module text_line_fetcher #(
  parameter int COLS    = 16,
  parameter int ROWS    = 4,
  parameter int X0      = 448,
  parameter int Y0      = 80,
  parameter int H_TRIG  = 640,
  parameter int H_TOTAL = 800,
  parameter int V_LINES = 525,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [6:0]    wr_char,
  output logic [10:0]   font_addr,
  input  logic [7:0]    font_data,
  output logic          busy,
  output logic          is_text
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] tr_r;
  logic [3:0]    gr_r;
  logic          line_valid_r;
  logic          cap_en_r;
  logic [CW-1:0] col_d_r;
  logic [7:0]    line_buf_r [COLS];
  logic [6:0]    charmem_r  [ROWS][COLS];

  logic [9:0]    ny_s;
  logic [10:0]   diff_s;
  logic          hit_s;
  logic [RW-1:0] tr_s;
  logic [3:0]    gr_s;
  logic [10:0]   dx_s;
  logic          in_win_s;
  logic [CW-1:0] c_s;
  logic [2:0]    b_s;
  logic          pix_s;
  logic          row_ok_s;
  logic          col_ok_s;
  logic [CW-1:0] col_nxt_s;

  // Range guards only exist when the address fields can exceed the array size.
  if ((1 << RW) > ROWS) begin : g_row_chk
    assign row_ok_s = (32'(wr_row) < ROWS);
  end else begin : g_row_full
    assign row_ok_s = 1'b1;
  end

  if ((1 << CW) > COLS) begin : g_col_chk
    assign col_ok_s = (32'(wr_col) < COLS);
  end else begin : g_col_full
    assign col_ok_s = 1'b1;
  end

  // Next-line window decode; an 11-bit subtract exposes ny < Y0 as the borrow bit.
  always_comb begin
    ny_s      = (DrawY == 10'(V_LINES - 1)) ? 10'd0 : (DrawY + 10'd1);
    diff_s    = {1'b0, ny_s} - 11'(Y0);
    hit_s     = (diff_s[10] == 1'b0) && (diff_s[9:0] < 10'(16 * ROWS));
    tr_s      = diff_s[RW+3:4];
    gr_s      = diff_s[3:0];
    col_nxt_s = col_r + CW'(1);
  end

  // Horizontal window decode and pixel select from the line buffer, MSB leftmost.
  always_comb begin
    dx_s     = {1'b0, DrawX} - 11'(X0);
    in_win_s = (dx_s[10] == 1'b0) && (dx_s[9:0] < 10'(8 * COLS));
    c_s      = dx_s[CW+2:3];
    b_s      = 3'd7 - dx_s[2:0];
    if (in_win_s) begin
      pix_s = line_buf_r[c_s][b_s];
    end else begin
      pix_s = 1'b0;
    end
  end

  // Character memory: cleared to blank on reset, out-of-range writes dropped.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          charmem_r[r][c] <= 7'h00;
        end
      end
    end else if (wr_en && row_ok_s && col_ok_s) begin
      charmem_r[wr_row][wr_col] <= wr_char;
    end
  end

  // Prefetch FSM; font_addr is issued one edge ahead so it is registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= IDLE;
      col_r        <= '0;
      tr_r         <= '0;
      gr_r         <= 4'd0;
      font_addr    <= 11'd0;
      busy         <= 1'b0;
      line_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (DrawX == 10'(H_TRIG)) begin
            line_valid_r <= 1'b0;
            if (hit_s) begin
              tr_r      <= tr_s;
              gr_r      <= gr_s;
              col_r     <= '0;
              font_addr <= {charmem_r[tr_s][0], gr_s};
              busy      <= 1'b1;
              state_r   <= FETCH;
            end
          end
        end
        FETCH: begin
          if (col_r == CW'(COLS - 1)) begin
            font_addr <= 11'd0;
            state_r   <= DRAIN;
          end else begin
            col_r     <= col_nxt_s;
            font_addr <= {charmem_r[tr_r][col_nxt_s], gr_r};
          end
        end
        DRAIN: begin
          line_valid_r <= 1'b1;
          busy         <= 1'b0;
          col_r        <= '0;
          state_r      <= IDLE;
        end
        default: begin
          font_addr <= 11'd0;
          busy      <= 1'b0;
          col_r     <= '0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Capture ROM data one cycle after each fetch address into the line buffer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_en_r <= 1'b0;
      col_d_r  <= '0;
      for (int c = 0; c < COLS; c++) begin
        line_buf_r[c] <= 8'h00;
      end
    end else begin
      cap_en_r <= (state_r == FETCH);
      col_d_r  <= col_r;
      if (cap_en_r) begin
        line_buf_r[col_d_r] <= font_data;
      end
    end
  end

  // Registered pixel flag, gated by a complete line buffer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_text <= 1'b0;
    end else begin
      is_text <= line_valid_r & pix_s;
    end
  end

endmodule

// File: tb/tb_text_line_fetcher.sv
// Scoreboard bench for text_line_fetcher: directed writes and scanline sweeps push
// expected font addresses and pixel flags; negedge monitors pop and compare.
module tb_text_line_fetcher;

  logic        Clk;
  logic        Reset_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        wr_en;
  logic [1:0]  wr_row;
  logic [3:0]  wr_col;
  logic [6:0]  wr_char;
  logic [10:0] fa_m, fa_w;
  logic [7:0]  fd_m, fd_w;
  logic        busy_m, busy_w;
  logic        it_m, it_w;

  int n_chk = 0;
  int n_err = 0;
  bit run_mon = 1'b0;
  bit pix_chk = 1'b0;
  bit pix_due = 1'b0;

  logic [10:0] aq_m [$];
  logic [10:0] aq_w [$];
  logic        pix_q [$];
  logic [10:0] exp_a  [16];
  logic [7:0]  exp_lb [16];

  text_line_fetcher u_main (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .font_addr(fa_m), .font_data(fd_m), .busy(busy_m), .is_text(it_m)
  );

  text_line_fetcher #(.Y0(0)) u_wrap (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .font_addr(fa_w), .font_data(fd_w), .busy(busy_w), .is_text(it_w)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom(input logic [10:0] a);
    return a[7:0] ^ {1'b0, a[10:4]};
  endfunction

  // Registered font ROM models, one per instance.
  always @(posedge Clk) begin
    fd_m <= rom(fa_m);
    fd_w <= rom(fa_w);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Address monitor for the main instance.
  always @(negedge Clk) begin
    if (run_mon) begin
      if (busy_m) begin
        if (aq_m.size() == 0) check("busy_m_unexpected", 32'(busy_m), 32'd0);
        else check("font_addr_m", 32'(fa_m), 32'(aq_m.pop_front()));
      end else begin
        check("idle_addr_m", 32'(fa_m), 32'd0);
      end
    end
  end

  // Address monitor for the wrap instance.
  always @(negedge Clk) begin
    if (run_mon) begin
      if (busy_w) begin
        if (aq_w.size() == 0) check("busy_w_unexpected", 32'(busy_w), 32'd0);
        else check("font_addr_w", 32'(fa_w), 32'(aq_w.pop_front()));
      end else begin
        check("idle_addr_w", 32'(fa_w), 32'd0);
      end
    end
  end

  // Pixel monitor: is_text lags the driven DrawX by one edge.
  always @(posedge Clk) pix_due <= pix_chk;

  always @(negedge Clk) begin
    if (pix_due) begin
      if (pix_q.size() == 0) check("pix_q_size", 32'(pix_q.size()), 32'd1);
      else check("is_text", 32'(it_m), 32'(pix_q.pop_front()));
    end
  end

  task automatic cyc(input int x, input int y, input bit chk, input logic e);
    DrawX   = 10'(x);
    DrawY   = 10'(y);
    pix_chk = chk;
    if (chk) pix_q.push_back(e);
    @(posedge Clk);
    #1;
    pix_chk = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input logic [6:0] ch);
    wr_en = 1'b1; wr_row = 2'(r); wr_col = 4'(c); wr_char = ch;
    cyc(0, 79, 1'b0, 1'b0);
    wr_en = 1'b0;
  endtask

  task automatic fill_a(input logic [3:0] gr);
    for (int i = 0; i < 16; i++) exp_a[i] = {7'h00, gr};
  endtask

  task automatic clear_lb();
    for (int i = 0; i < 16; i++) exp_lb[i] = 8'h00;
  endtask

  // Blank-region sweep; pushes exp_a + DRAIN zero when a fetch is expected.
  task automatic prefetch(input int y, input int which, input bit hit,
                          input int coll_col, input logic [6:0] coll_ch);
    if (hit) begin
      for (int i = 0; i < 16; i++) begin
        if (which == 0) aq_m.push_back(exp_a[i]);
        else aq_w.push_back(exp_a[i]);
      end
      if (which == 0) aq_m.push_back(11'h000);
      else aq_w.push_back(11'h000);
    end
    for (int x = 640; x <= 660; x++) begin
      if (coll_col >= 0 && x == 641 + coll_col) begin
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 4'(coll_col); wr_char = coll_ch;
      end else begin
        wr_en = 1'b0;
      end
      cyc(x, y, 1'b0, 1'b0);
    end
    wr_en = 1'b0;
    check("addr_q_drained", 32'((which == 0) ? aq_m.size() : aq_w.size()), 32'd0);
  endtask

  // Visible sweep across the window with a margin on both sides.
  task automatic display(input int y);
    logic [7:0] byte_v;
    logic       e;
    for (int x = 440; x <= 583; x++) begin
      if (x >= 448 && x < 576) begin
        byte_v = exp_lb[(x - 448) >> 3];
        e = byte_v[7 - ((x - 448) & 7)];
      end else begin
        e = 1'b0;
      end
      cyc(x, y, 1'b1, e);
    end
    cyc(600, y, 1'b0, 1'b0);
  endtask

  initial begin
    Reset_n = 1'b0; DrawX = 10'd640; DrawY = 10'd79;
    wr_en = 1'b0; wr_row = 2'd0; wr_col = 4'd0; wr_char = 7'h00;
    @(posedge Clk); #1;
    run_mon = 1'b1;
    repeat (3) cyc(640, 79, 1'b0, 1'b0);
    check("rst_is_text", 32'(it_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_font_addr", 32'(fa_m), 32'd0);
    check("rst_busy_w", 32'(busy_w), 32'd0);
    check("rst_is_text_w", 32'(it_w), 32'd0);
    DrawX = 10'd0;
    Reset_n = 1'b1;
    cyc(0, 79, 1'b0, 1'b0);

    // Blank memory after reset: line 80 fetches code 0 and shows nothing.
    fill_a(4'h0);
    prefetch(79, 0, 1'b1, -1, 7'h00);
    clear_lb();
    display(80);

    // Basic fetch of 'T' at row 0 col 0.
    wr(0, 0, 7'h54);
    fill_a(4'h0); exp_a[0] = 11'h540;
    prefetch(79, 0, 1'b1, -1, 7'h00);
    clear_lb(); exp_lb[0] = 8'h14;
    display(80);

    // Text row boundary: ny=96 is tr=1 gr=0.
    wr(1, 0, 7'h41);
    wr(1, 3, 7'h7F);
    fill_a(4'h0); exp_a[0] = 11'h410; exp_a[3] = 11'h7F0;
    prefetch(95, 0, 1'b1, -1, 7'h00);
    clear_lb(); exp_lb[0] = 8'h51; exp_lb[3] = 8'h8F;
    display(96);

    // Last glyph row of text row 1: ny=111 is gr=15.
    fill_a(4'hF); exp_a[0] = 11'h41F; exp_a[3] = 11'h7FF;
    prefetch(110, 0, 1'b1, -1, 7'h00);

    // Miss below the window: no fetch, previous line invalidated.
    prefetch(143, 0, 1'b0, -1, 7'h00);
    clear_lb();
    display(144);

    // Write collision at col 5: old code fetched, new code on the next line.
    wr(0, 5, 7'h30);
    fill_a(4'h0); exp_a[0] = 11'h540; exp_a[5] = 11'h300;
    prefetch(79, 0, 1'b1, 5, 7'h31);
    clear_lb(); exp_lb[0] = 8'h14; exp_lb[5] = 8'h30;
    display(80);
    fill_a(4'h1); exp_a[0] = 11'h541; exp_a[5] = 11'h311;
    prefetch(80, 0, 1'b1, -1, 7'h00);

    // Frame wrap on the Y0=0 instance: ny=0 then ny=1.
    fill_a(4'h0); exp_a[0] = 11'h540; exp_a[5] = 11'h310;
    prefetch(524, 1, 1'b1, -1, 7'h00);
    fill_a(4'h1); exp_a[0] = 11'h541; exp_a[5] = 11'h311;
    prefetch(0, 1, 1'b1, -1, 7'h00);

    // Reset asserted while col=7 is being addressed.
    fill_a(4'h0); exp_a[0] = 11'h540; exp_a[5] = 11'h310;
    for (int i = 0; i < 16; i++) aq_m.push_back(exp_a[i]);
    aq_m.push_back(11'h000);
    for (int x = 640; x <= 647; x++) cyc(x, 79, 1'b0, 1'b0);
    Reset_n = 1'b0;
    aq_m.delete();
    #1;
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_font_addr", 32'(fa_m), 32'd0);
    cyc(648, 79, 1'b0, 1'b0);
    cyc(649, 79, 1'b0, 1'b0);
    Reset_n = 1'b1;
    cyc(650, 79, 1'b0, 1'b0);
    clear_lb();
    display(80);
    wr(0, 2, 7'h5A);
    fill_a(4'h0); exp_a[2] = 11'h5A0;
    prefetch(79, 0, 1'b1, -1, 7'h00);
    clear_lb(); exp_lb[2] = 8'hFA;
    display(80);

    repeat (3) cyc(0, 79, 1'b0, 1'b0);
    check("pix_q_drained", 32'(pix_q.size()), 32'd0);
    check("aq_w_drained", 32'(aq_w.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
